// File: rtl/spart_msg_link.sv
// Message framing between the game controller and the spart byte UART.
// TX wraps a 32-bit message as SYNC/4 payload bytes/XOR checksum; RX hunts, checks and unwraps.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// TX_IDLE     | ready for a new message
// TX_ISSUE    | waiting for tbr, then pulses send_tx with byte[idx]
// TX_HOLD     | one cycle after send_tx; tbr still reflects the old byte
// TX_DRAIN    | waiting for spart to finish the byte, then advance idx
// RX_HUNT     | discarding bytes until SYNC
// RX_PAYLOAD  | assembling four payload bytes, MSB first
// RX_CSUM     | comparing the checksum byte against the assembled payload
module spart_msg_link #(
    parameter logic [7:0] SYNC        = 8'hA5,
    parameter int         TIMEOUT_CYC = 40000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] tx_msg,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [31:0] rx_msg,
    output logic        rx_valid,
    output logic        rx_err,
    output logic        rx_err_type,
    output logic        send_tx,
    output logic [7:0]  tx_data,
    input  logic        tbr,
    input  logic [7:0]  rx_data,
    input  logic        rda
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC);

    typedef enum logic [1:0] {TX_IDLE, TX_ISSUE, TX_HOLD, TX_DRAIN} tx_state_t;
    typedef enum logic [1:0] {RX_HUNT, RX_PAYLOAD, RX_CSUM} rx_state_t;

    tx_state_t tx_state, tx_state_nxt;
    logic [31:0] tx_buf;
    logic [7:0]  tx_csum;
    logic [2:0]  tx_idx;
    logic [7:0]  tx_byte;
    logic        tx_load, tx_fire, tx_adv;

    rx_state_t rx_state, rx_state_nxt;
    logic [31:0]   rx_asm;
    logic [1:0]    rx_cnt;
    logic [TW-1:0] rx_timer;
    logic [7:0]    rx_asm_csum;
    logic          rx_shift, rx_good, rx_bad, rx_tmo;

    assign tx_ready = (tx_state == TX_IDLE);

    always_comb begin
        case (tx_idx)
            3'd0:    tx_byte = SYNC;
            3'd1:    tx_byte = tx_buf[31:24];
            3'd2:    tx_byte = tx_buf[23:16];
            3'd3:    tx_byte = tx_buf[15:8];
            3'd4:    tx_byte = tx_buf[7:0];
            default: tx_byte = tx_csum;
        endcase
    end

    always_comb begin
        tx_state_nxt = tx_state;
        tx_load      = 1'b0;
        tx_fire      = 1'b0;
        tx_adv       = 1'b0;
        case (tx_state)
            TX_IDLE: if (tx_valid) begin
                tx_load      = 1'b1;
                tx_state_nxt = TX_ISSUE;
            end
            TX_ISSUE: if (tbr) begin
                tx_fire      = 1'b1;
                tx_state_nxt = TX_HOLD;
            end
            TX_HOLD: tx_state_nxt = TX_DRAIN;
            TX_DRAIN: if (tbr) begin
                tx_adv       = 1'b1;
                tx_state_nxt = (tx_idx == 3'd5) ? TX_IDLE : TX_ISSUE;
            end
            default: tx_state_nxt = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state <= TX_IDLE;
            tx_buf   <= '0;
            tx_csum  <= '0;
            tx_idx   <= '0;
            send_tx  <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_state <= tx_state_nxt;
            send_tx  <= tx_fire;
            if (tx_load) begin
                tx_buf  <= tx_msg;
                tx_csum <= tx_msg[31:24] ^ tx_msg[23:16] ^ tx_msg[15:8] ^ tx_msg[7:0];
                tx_idx  <= '0;
            end
            if (tx_fire) tx_data <= tx_byte;
            if (tx_adv)  tx_idx  <= tx_idx + 3'd1;
        end
    end

    assign rx_asm_csum = rx_asm[31:24] ^ rx_asm[23:16] ^ rx_asm[15:8] ^ rx_asm[7:0];

    // A byte arriving in the expiry cycle takes priority over the timeout.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_shift     = 1'b0;
        rx_good      = 1'b0;
        rx_bad       = 1'b0;
        rx_tmo       = 1'b0;
        case (rx_state)
            RX_HUNT: if (rda && rx_data == SYNC) rx_state_nxt = RX_PAYLOAD;
            RX_PAYLOAD: begin
                if (rda) begin
                    rx_shift = 1'b1;
                    if (rx_cnt == 2'd3) rx_state_nxt = RX_CSUM;
                end else if (rx_timer == TMAX) begin
                    rx_tmo       = 1'b1;
                    rx_state_nxt = RX_HUNT;
                end
            end
            RX_CSUM: begin
                if (rda) begin
                    if (rx_data == rx_asm_csum) rx_good = 1'b1;
                    else                        rx_bad  = 1'b1;
                    rx_state_nxt = RX_HUNT;
                end else if (rx_timer == TMAX) begin
                    rx_tmo       = 1'b1;
                    rx_state_nxt = RX_HUNT;
                end
            end
            default: rx_state_nxt = RX_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state    <= RX_HUNT;
            rx_asm      <= '0;
            rx_cnt      <= '0;
            rx_timer    <= '0;
            rx_msg      <= '0;
            rx_valid    <= 1'b0;
            rx_err      <= 1'b0;
            rx_err_type <= 1'b0;
        end else begin
            rx_state <= rx_state_nxt;
            rx_valid <= rx_good;
            rx_err   <= rx_bad | rx_tmo;
            if (rx_state == RX_HUNT) rx_cnt <= '0;
            else if (rx_shift)       rx_cnt <= rx_cnt + 2'd1;
            if (rx_shift) rx_asm <= {rx_asm[23:0], rx_data};
            if (rx_good)  rx_msg <= rx_asm;
            if (rx_bad)   rx_err_type <= 1'b0;
            if (rx_tmo)   rx_err_type <= 1'b1;
            if (rx_state == RX_HUNT || rda) rx_timer <= '0;
            else if (rx_timer != TMAX)      rx_timer <= rx_timer + 1'b1;
        end
    end

endmodule

// File: tb/tb_spart_msg_link.sv
// Scoreboard bench for spart_msg_link: stimulus pushes expected TX bytes / RX results,
// negedge monitors pop and compare whenever the DUT presents send_tx, rx_valid or rx_err.
module tb_spart_msg_link;
    localparam int T       = 1000;
    localparam int TBR_LOW = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] tx_msg = '0;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [31:0] rx_msg;
    logic        rx_valid, rx_err, rx_err_type;
    logic        send_tx;
    logic [7:0]  tx_data;
    logic        tbr;
    logic [7:0]  rx_data = '0;
    logic        rda = 1'b0;

    spart_msg_link #(.SYNC(8'hA5), .TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst_n(rst_n), .tx_msg(tx_msg), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_msg(rx_msg), .rx_valid(rx_valid), .rx_err(rx_err), .rx_err_type(rx_err_type),
        .send_tx(send_tx), .tx_data(tx_data), .tbr(tbr), .rx_data(rx_data), .rda(rda)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_err_cyc = 0;
    int tx_pulses = 0;

    typedef struct {
        logic        is_err;
        logic        etype;
        logic [31:0] msg;
    } rx_exp_t;
    rx_exp_t    rx_q[$];
    logic [7:0] tx_q[$];

    always @(posedge clk) cyc++;

    // spart transmitter model: tbr drops for TBR_LOW cycles after each accepted byte.
    int   tbr_busy = 0;
    logic sent_s;
    assign tbr = (tbr_busy == 0);
    always @(posedge clk) begin
        sent_s = send_tx;
        #1;
        if (!rst_n)            tbr_busy = 0;
        else if (sent_s)       tbr_busy = TBR_LOW;
        else if (tbr_busy > 0) tbr_busy--;
    end
    always @(negedge rst_n) tbr_busy = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic prev_send = 1'b0;
    always @(negedge clk) begin
        logic [7:0] e;
        if (send_tx) begin
            tx_pulses++;
            chk("send_tx_width", 32'(prev_send), 32'd0);
            if (tx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte %h expected no send_tx", tx_data);
            end else begin
                e = tx_q.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e));
            end
        end
        prev_send = send_tx;
    end

    always @(negedge clk) begin
        rx_exp_t e;
        if (rx_valid || rx_err) begin
            chk("rx_valid_err_exclusive", 32'(rx_valid & rx_err), 32'd0);
            if (rx_err) last_err_cyc = cyc;
            if (rx_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rx_unexpected: got valid=%b err=%b msg=%h expected nothing",
                         rx_valid, rx_err, rx_msg);
            end else begin
                e = rx_q.pop_front();
                chk("rx_kind_err", 32'(rx_err), 32'(e.is_err));
                chk("rx_msg", rx_msg, e.msg);
                if (e.is_err) chk("rx_err_type", 32'(rx_err_type), 32'(e.etype));
            end
        end
    end

    task automatic push_rx(input logic is_err, input logic etype, input logic [31:0] msg);
        rx_exp_t e;
        e.is_err = is_err;
        e.etype  = etype;
        e.msg    = msg;
        rx_q.push_back(e);
    endtask

    // Byte is sampled gap+1 edges after the previous byte's sampling edge.
    task automatic rx_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        rx_data = b;
        rda = 1'b1;
        @(posedge clk);
        #1;
        rda = 1'b0;
        rx_data = 8'h00;
    endtask

    task automatic rx_frame6(input logic [47:0] f, input int gap);
        for (int i = 5; i >= 0; i--) rx_byte(f[i*8 +: 8], gap);
    endtask

    task automatic wait_rx(input int lim);
        int k = 0;
        while (rx_q.size() != 0 && k < lim) begin
            @(negedge clk);
            k++;
        end
        chk("rx_wait_budget", 32'(rx_q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic tx_send(input logic [31:0] m);
        int k = 0;
        while (!tx_ready && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("tx_ready_before", 32'(tx_ready), 32'd1);
        tx_msg   = m;
        tx_valid = 1'b1;
        tx_q.push_back(8'hA5);
        tx_q.push_back(m[31:24]);
        tx_q.push_back(m[23:16]);
        tx_q.push_back(m[15:8]);
        tx_q.push_back(m[7:0]);
        tx_q.push_back(m[31:24] ^ m[23:16] ^ m[15:8] ^ m[7:0]);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
        chk("tx_ready_fall", 32'(tx_ready), 32'd0);
        chk("send_tx_not_yet", 32'(send_tx), 32'd0);
        @(posedge clk);
        #1;
        chk("first_send_tx_latency", 32'(send_tx), 32'd1);
    endtask

    task automatic tx_wait_done();
        int k = 0;
        while (!(tx_ready && tx_q.size() == 0) && k < 2000) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("tx_done_ready", 32'(tx_ready), 32'd1);
        chk("tx_done_queue", 32'(tx_q.size()), 32'd0);
        chk("tx_pulse_count", 32'(tx_pulses), 32'd6);
    endtask

    initial begin
        int start;
        int k;
        #2;
        chk("rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("rst_send_tx", 32'(send_tx), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_rx_msg", rx_msg, 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_err", 32'(rx_err), 32'd0);
        chk("rst_rx_err_type", 32'(rx_err_type), 32'd0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        tx_pulses = 0;
        tx_send(32'h01020304);
        tx_wait_done();

        push_rx(1'b0, 1'b0, 32'hDEADBEEF);
        rx_byte(8'h33, 3);
        rx_frame6(48'hA5_DEADBEEF_22, 3);
        wait_rx(100);

        push_rx(1'b1, 1'b0, 32'hDEADBEEF);
        rx_frame6(48'hA5_11223344_00, 3);
        wait_rx(100);

        push_rx(1'b1, 1'b1, 32'hDEADBEEF);
        rx_byte(8'hA5, 3);
        rx_byte(8'h11, 3);
        start = cyc;
        wait_rx(T + 50);
        chk("timeout_latency", 32'(last_err_cyc - start), 32'(T + 1));
        push_rx(1'b0, 1'b0, 32'h00000001);
        rx_frame6(48'hA5_00000001_01, 3);
        wait_rx(100);

        push_rx(1'b0, 1'b0, 32'hA5A5A5A5);
        rx_frame6(48'hA5_A5A5A5A5_00, 3);
        wait_rx(100);

        // Every byte lands exactly in the expiry cycle; the bytes must win.
        push_rx(1'b0, 1'b0, 32'h0BADF00D);
        rx_frame6(48'hA5_0BADF00D_5B, T);
        wait_rx(T + 50);

        tx_pulses = 0;
        push_rx(1'b0, 1'b0, 32'h12345678);
        fork
            begin
                tx_send(32'hCAFE0042);
                repeat (50) @(posedge clk);
                #1;
                chk("busy_tx_ready", 32'(tx_ready), 32'd0);
                tx_msg   = 32'hFFFFFFFF;
                tx_valid = 1'b1;
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
                tx_wait_done();
            end
            rx_frame6(48'hA5_12345678_08, 20);
        join
        wait_rx(100);

        tx_pulses = 0;
        rx_byte(8'hA5, 3);
        rx_byte(8'h77, 3);
        tx_send(32'h55AA55AA);
        k = 0;
        while (!(send_tx && tx_pulses >= 3) && k < 1000) begin
            @(negedge clk);
            k++;
        end
        chk("mid_tx_pulse_seen", 32'(send_tx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_send_tx", 32'(send_tx), 32'd0);
        chk("async_rst_tx_ready", 32'(tx_ready), 32'd1);
        chk("async_rst_tx_data", 32'(tx_data), 32'd0);
        tx_q.delete();
        rx_q.delete();
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        chk("post_rst_tx_idle", 32'(tx_ready), 32'd1);
        chk("post_rst_rx_msg", rx_msg, 32'd0);
        push_rx(1'b0, 1'b0, 32'h01020304);
        rx_frame6(48'hA5_01020304_04, 3);
        wait_rx(100);

        chk("final_tx_queue", 32'(tx_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL global_timeout: got no finish expected finish before 5ms");
        $fatal(1);
    end
endmodule

// File: doc/spart_msg_link.md
# spart_msg_link

Message framing layer between the game controller and the spart byte UART. On transmit it takes a 32-bit game message and sends it as a 6-byte frame through spart's `send_tx`/`tbr` handshake: sync byte, four payload bytes, checksum. On receive it hunts for the sync byte in spart's `rx_data`/`rda` byte stream, assembles the payload, checks it, and presents a validated 32-bit message or an error pulse. The TX and RX paths are independent and run concurrently.

## Interface
- `SYNC`, default 8'hA5: frame start byte.
- `TIMEOUT_CYC`, default 40000: maximum clk cycles allowed between bytes inside an RX frame (about 3 byte times at spart's baud).
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset; one clock domain, no other clocks.
- `tx_msg`  in  32  message to send; sampled only when `tx_valid & tx_ready`.
- `tx_valid`  in  1  request to send `tx_msg`.
- `tx_ready`  out  1  high only in TX IDLE.
- `rx_msg`  out  32  last good received message; holds its value between frames.
- `rx_valid`  out  1  one-cycle pulse; `rx_msg` has just been updated.
- `rx_err`  out  1  one-cycle pulse; the frame was dropped.
- `rx_err_type`  out  1  0 = checksum mismatch, 1 = timeout; valid when `rx_err` is high and held until the next error.
- `send_tx`  out  1  registered; to spart `send_tx`.
- `tx_data`  out  8  registered; to spart `tx_data`.
- `tbr`  in  1  from spart; transmit buffer ready.
- `rx_data`  in  8  from spart; valid only while `rda` is high.
- `rda`  in  1  from spart; one-cycle byte-valid pulse.

## Operation
- Frame layout, in wire order: `SYNC`, `msg[31:24]`, `msg[23:16]`, `msg[15:8]`, `msg[7:0]`, `CSUM`.
- `CSUM` is the XOR of the four payload bytes. `SYNC` is not included.
- TX FSM:
  - IDLE: `tx_ready`=1. On `tx_valid`, latch the message, compute `CSUM`, set idx=0, go to ISSUE.
  - ISSUE: when `tbr`=1, register `send_tx`<=1 and `tx_data`<=byte[idx], then go to HOLD.
  - HOLD: lasts exactly one cycle. `send_tx`<=0, go to DRAIN. `tbr` is not examined in HOLD, because spart's `tbr` is still high during the cycle it accepts a byte.
  - DRAIN: when `tbr`=1, increment idx. If idx was 5, go to IDLE; otherwise go to ISSUE.
- RX FSM:
  - HUNT: on `rda` with `rx_data`==`SYNC`, set cnt=0 and go to PAYLOAD. Any other byte is discarded.
  - PAYLOAD: on each `rda`, shift the byte into a 32-bit assembly register, MSB byte first. After the 4th byte, go to CSUM.
  - CSUM: on `rda`, compare the byte with the XOR of the assembly register bytes.
    - Match: `rx_msg`<=assembly register, `rx_valid` pulses.
    - Mismatch: `rx_err` pulses, `rx_err_type`<=0.
    - In both cases, go to HUNT.
- `SYNC` arriving inside PAYLOAD or CSUM is treated as ordinary data; there is no resync mid-frame.
- RX timeout counter:
  - Cleared on every `rda` and whenever the FSM is in HUNT.
  - Increments each cycle in PAYLOAD and CSUM; the counter is `$clog2(TIMEOUT_CYC+1)` bits and never wraps.
  - When it reaches `TIMEOUT_CYC`: `rx_err` pulses, `rx_err_type`<=1, go to HUNT.
- Boundary rules:
  - `rda` and timeout expiry in the same cycle: `rda` wins; the byte is consumed and the counter cleared.
  - `tx_valid` while `tx_ready`=0: ignored, not queued.
  - Reset mid-frame: both FSMs return to their idle states immediately. A TX frame cut short is not resumed. spart is reset by the same `rst_n`.

## Timing
- Reset values: `tx_ready`=1, `send_tx`=0, `tx_data`=0, `rx_msg`=0, `rx_valid`=0, `rx_err`=0, `rx_err_type`=0. TX FSM = IDLE, RX FSM = HUNT.
- `tx_ready` falls the cycle after acceptance and rises the cycle after the 6th DRAIN completes.
- `send_tx` is high for exactly 1 cycle per byte, 6 pulses per frame.
- Earliest first `send_tx`: 2 cycles after `tx_valid` is accepted, provided `tbr`=1.
- `rx_valid` / `rx_err` assert the cycle after the `rda` that carries the CSUM byte. A timeout error asserts the cycle after the counter reaches `TIMEOUT_CYC`.
- `rx_valid` and `rx_err` are never high in the same cycle.

## Test plan
- Reset, then send `tx_msg`=32'h01020304 with a spart model that holds `tbr` low for 100 cycles per byte -> `tx_data` sequence A5,01,02,03,04,04; exactly 6 `send_tx` pulses; `tx_ready` high again at the end.
- Inject RX bytes 33,A5,DE,AD,BE,EF,22 -> `rx_valid` pulses once, `rx_msg`=32'hDEADBEEF; the leading 33 is ignored.
- Inject A5,11,22,33,44,00 -> `rx_err`=1 with `rx_err_type`=0; `rx_msg` unchanged.
- Inject A5,11, then no `rda` for `TIMEOUT_CYC` cycles -> `rx_err` with `rx_err_type`=1. A following good frame A5,00,00,00,01,01 -> `rx_valid`, `rx_msg`=1.
- Inject A5,A5,A5,A5,A5,00 -> `rx_valid`, `rx_msg`=32'hA5A5A5A5 (sync byte accepted as payload).
- Run a full TX frame and an RX frame concurrently, and pulse `tx_valid` while busy -> both complete correctly, the busy request is dropped, and asserting `rst_n`=0 mid-TX sets `send_tx`=0 and `tx_ready`=1 asynchronously.
